alu_md_unit: RTL and testbench

- Parametrised next-generation execute unit for the pipelined MIPS core: a full combinational ALU (arithmetic, logic, compare, shift, LUI) plus a multi-cycle multiply/divide engine owning the HI/LO registers.
- Sits in the EX stage.
- `stall` feeds the hazard unit.
- `md_done` feeds the scoreboard.

---
 rtl/alu_md_pkg.sv | 36 +++
 rtl/md_engine.sv | 136 +++++++++++++
 rtl/alu_md_unit.sv | 85 ++++++++
 tb/tb_alu_md_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_md_pkg.sv
// Shared opcodes and FSM state encoding for the EX-stage ALU and multiply/divide engine.
package alu_md_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_AND  = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11,
        ALU_MFHI = 4'd12,
        ALU_MFLO = 4'd13
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_engine.sv
// Multi-cycle multiply/divide engine owning HI/LO; results land after a fixed latency.
module md_engine
    import alu_md_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [2:0]       md_op,
    input  logic             md_start,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             md_done,
    output logic             div0
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);
    localparam int unsigned DW      = 2 * WIDTH;

    md_state_e        state;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    prod_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic             sgn_q;

    logic             mul_sgn;
    logic [DW-1:0]    mul_a;
    logic [DW-1:0]    mul_b;
    logic [DW-1:0]    product;

    // Full-width product is captured at acceptance so later operand changes are harmless.
    assign mul_sgn = (md_op == MD_MULT);
    assign mul_a   = {{WIDTH{mul_sgn & num1[WIDTH-1]}}, num1};
    assign mul_b   = {{WIDTH{mul_sgn & num2[WIDTH-1]}}, num2};
    assign product = mul_a * mul_b;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH-1:0] dvs_safe;
    logic [WIDTH-1:0] quo_u;
    logic [WIDTH-1:0] rem_u;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    // Sign-magnitude divide: truncate toward zero, remainder follows the dividend.
    always_comb begin
        dvd_neg  = sgn_q & dvd_q[WIDTH-1];
        dvs_neg  = sgn_q & dvs_q[WIDTH-1];
        dvd_abs  = dvd_neg ? -dvd_q : dvd_q;
        dvs_abs  = dvs_neg ? -dvs_q : dvs_q;
        dvs_safe = (dvs_abs == '0) ? WIDTH'(1) : dvs_abs;
        quo_u    = dvd_abs / dvs_safe;
        rem_u    = dvd_abs % dvs_safe;
        quo      = (dvd_neg ^ dvs_neg) ? -quo_u : quo_u;
        rem      = dvd_neg ? -rem_u : rem_u;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            prod_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            sgn_q   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            md_done <= 1'b0;
            div0    <= 1'b0;
        end else begin
            md_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (md_start) begin
                        case (md_op)
                            MD_MULT, MD_MULTU: begin
                                prod_q <= product;
                                cnt    <= CW'(MUL_LAT - 1);
                                state  <= ST_MUL;
                                busy   <= 1'b1;
                                div0   <= 1'b0;
                            end
                            MD_DIV, MD_DIVU: begin
                                dvd_q  <= num1;
                                dvs_q  <= num2;
                                sgn_q  <= (md_op == MD_DIV);
                                cnt    <= CW'(DIV_LAT - 1);
                                state  <= ST_DIV;
                                busy   <= 1'b1;
                                div0   <= (num2 == '0);
                            end
                            MD_MTHI: hi <= num1;
                            MD_MTLO: lo <= num1;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt == '0) begin
                        {hi, lo} <= prod_q;
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        md_done  <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_DIV: begin
                    if (cnt == '0) begin
                        if (dvs_q != '0) begin
                            lo <= quo;
                            hi <= rem;
                        end
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        md_done <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_md_unit.sv
// EX-stage execute unit: combinational ALU plus the multi-cycle multiply/divide engine.
module alu_md_unit
    import alu_md_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [3:0]       alu_op,
    input  logic [2:0]       md_op,
    input  logic             md_start,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             md_done,
    output logic             div0
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    md_engine #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md (
        .clk      (clk),
        .rst_n    (rst_n),
        .num1     (num1),
        .num2     (num2),
        .md_op    (md_op),
        .md_start (md_start),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .md_done  (md_done),
        .div0     (div0)
    );

    assign stall = md_start | busy;
    assign zero  = (num1 == num2);
    assign shamt = num1[SHW-1:0];
    assign sum   = num1 + num2;
    assign diff  = num1 - num2;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                result   = sum;
                overflow = (num1[WIDTH-1] == num2[WIDTH-1]) && (sum[WIDTH-1] != num1[WIDTH-1]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (num1[WIDTH-1] != num2[WIDTH-1]) && (diff[WIDTH-1] != num1[WIDTH-1]);
            end
            ALU_OR:   result = num1 | num2;
            ALU_AND:  result = num1 & num2;
            ALU_XOR:  result = num1 ^ num2;
            ALU_NOR:  result = ~(num1 | num2);
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(num1) < $signed(num2))};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (num1 < num2)};
            ALU_SLL:  result = num2 << shamt;
            ALU_SRL:  result = num2 >> shamt;
            ALU_SRA:  result = $signed(num2) >>> shamt;
            ALU_LUI:  result = num2 << (WIDTH / 2);
            ALU_MFHI: result = hi;
            ALU_MFLO: result = lo;
            default:  result = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_md_unit.sv
// Self-checking bench for alu_md_unit: direct ALU vectors plus a scoreboard of HI/LO results.
module tb_alu_md_unit;
    import alu_md_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] num1;
    logic [31:0] num2;
    logic [3:0]  alu_op;
    logic [2:0]  md_op;
    logic        md_start;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        md_done;
    logic        div0;

    int n_vec = 0;
    int n_err = 0;
    exp_t sb[$];
    logic [31:0] mhi;
    logic [31:0] mlo;
    logic        mdiv0;

    alu_md_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .num1     (num1),
        .num2     (num2),
        .alu_op   (alu_op),
        .md_op    (md_op),
        .md_start (md_start),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall    (stall),
        .md_done  (md_done),
        .div0     (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference HI/LO behaviour, 64-bit arithmetic keeps MIN_INT / -1 well defined.
    function automatic void model_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb_v;
        logic [63:0] p;
        case (op)
            MD_MULT: begin
                sa = longint'($signed(a));
                sb_v = longint'($signed(b));
                p = 64'(sa * sb_v);
                {mhi, mlo} = p;
                mdiv0 = 1'b0;
            end
            MD_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                {mhi, mlo} = p;
                mdiv0 = 1'b0;
            end
            MD_DIV: begin
                mdiv0 = (b == 32'd0);
                if (b != 32'd0) begin
                    sa = longint'($signed(a));
                    sb_v = longint'($signed(b));
                    mlo = 32'(sa / sb_v);
                    mhi = 32'(sa % sb_v);
                end
            end
            MD_DIVU: begin
                mdiv0 = (b == 32'd0);
                if (b != 32'd0) begin
                    mlo = a / b;
                    mhi = a % b;
                end
            end
            MD_MTHI: mhi = a;
            MD_MTLO: mlo = a;
            default: ;
        endcase
    endfunction

    // Drive one accepted MD request; operands are scrambled afterwards.
    task automatic start_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit track);
        exp_t e;
        if (track) begin
            model_md(op, a, b);
            if (op <= MD_DIVU) begin
                e.hi = mhi;
                e.lo = mlo;
                e.div0 = mdiv0;
                sb.push_back(e);
            end
        end
        md_op = op;
        num1 = a;
        num2 = b;
        md_start = 1'b1;
        @(negedge clk);
        check("stall_on_start", 64'(stall), 64'd1);
        tick();
        md_start = 1'b0;
        num1 = $urandom;
        num2 = $urandom;
    endtask

    task automatic wait_busy(input int exp_cycles, input string tag);
        int n = 0;
        while (n < 60) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            tick();
        end
        check(tag, 64'(n), 64'(exp_cycles));
        check("done_pulse", 64'(md_done), 64'd1);
        tick();
        @(negedge clk);
        check("done_one_cycle", 64'(md_done), 64'd0);
        tick();
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_ov, input string tag);
        alu_op = op;
        num1 = a;
        num2 = b;
        #1;
        check(tag, 64'(result), 64'(exp_res));
        check({tag, "_ov"}, 64'(overflow), 64'(exp_ov));
    endtask

    // Scoreboard: every md_done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (md_done) begin
            if (sb.size() == 0) begin
                check("spurious_md_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_hi", 64'(hi), 64'(e.hi));
                check("sb_lo", 64'(lo), 64'(e.lo));
                check("sb_div0", 64'(div0), 64'(e.div0));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        num1 = '0;
        num2 = '0;
        alu_op = '0;
        md_op = '0;
        md_start = 1'b0;
        mhi = '0;
        mlo = '0;
        mdiv0 = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(md_done), 64'd0);
        check("rst_div0", 64'(div0), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        alu(ALU_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b1, "add_ovf");
        alu(ALU_ADD,  32'd5,         32'd3,         32'd8,         1'b0, "add");
        alu(ALU_SUB,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b1, "sub_ovf");
        alu(ALU_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0, "sub");
        alu(ALU_OR,   32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, "or");
        alu(ALU_AND,  32'h0000_0FF0, 32'h0000_00FF, 32'h0000_00F0, 1'b0, "and");
        alu(ALU_XOR,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b0, "xor");
        alu(ALU_NOR,  32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, "nor");
        alu(ALU_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, "slt");
        alu(ALU_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, "sltu");
        alu(ALU_SLL,  32'h24,        32'h1,         32'h10,        1'b0, "sll_mask");
        alu(ALU_SRL,  32'd4,         32'h8000_0000, 32'h0800_0000, 1'b0, "srl");
        alu(ALU_SRA,  32'd4,         32'h8000_0000, 32'hF800_0000, 1'b0, "sra");
        alu(ALU_LUI,  32'h0,         32'h1234,      32'h1234_0000, 1'b0, "lui");
        alu(4'd15,    32'h1234_5678, 32'h1234_5678, 32'h0,         1'b0, "undef_op");
        check("zero_eq", 64'(zero), 64'd1);
        num2 = 32'h1234_5679;
        #1;
        check("zero_ne", 64'(zero), 64'd0);
        tick();

        start_md(MD_MTHI, 32'h55, 32'h0, 1'b1);
        @(negedge clk);
        check("mthi_hi", 64'(hi), 64'h55);
        check("mthi_busy", 64'(busy), 64'd0);
        tick();
        start_md(MD_MTLO, 32'h1234, 32'h0, 1'b1);
        alu(ALU_MFHI, 32'h0, 32'h0, 32'h55,   1'b0, "mfhi");
        alu(ALU_MFLO, 32'h0, 32'h0, 32'h1234, 1'b0, "mflo");

        start_md(MD_MULT, 32'd3, 32'd4, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        mhi = '0;
        mlo = '0;
        mdiv0 = 1'b0;
        repeat (12) tick();

        start_md(MD_MULT,  32'hFFFF_FFFE, 32'd3, 1'b1);
        wait_busy(5, "mult_busy_cycles");
        start_md(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b1);
        wait_busy(5, "multu_busy_cycles");
        check("multu_hi_direct", 64'(hi), 64'h2);
        start_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_busy(10, "div_busy_cycles");
        start_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_busy(10, "div_minint_busy");

        start_md(MD_DIVU, 32'd5, 32'd0, 1'b1);
        tick();
        tick();
        md_op = MD_MTLO;
        num1 = 32'hAA;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        wait_busy(7, "divu0_busy_tail");
        check("div0_flag", 64'(div0), 64'd1);
        check("mtlo_ignored", 64'(lo), 64'h8000_0000);

        start_md(MD_MULT, 32'd7, 32'd6, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("b2b_stall_a", 64'(stall), 64'd1);
            tick();
        end
        start_md(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("b2b_stall_b", 64'(stall), 64'd1);
            tick();
        end
        @(negedge clk);
        check("b2b_stall_end", 64'(stall), 64'd0);
        check("b2b_done", 64'(md_done), 64'd1);
        tick();
        check("div0_cleared", 64'(div0), 64'd0);
        repeat (3) tick();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
